// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: EX operand forwarding from MEM/WB plus load-use and
// data-memory-wait stall sequencing, with saturating stall counters.
module hazard_fwd_unit #(
   parameter int NUM_SRC   = 2,
   parameter int REG_AW    = 5,
   parameter int LU_CYCLES = 1,
   parameter int CNT_W     = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      id_valid,
   input  logic [NUM_SRC*REG_AW-1:0] id_rs,
   input  logic [NUM_SRC-1:0]        id_rs_used,
   input  logic [NUM_SRC*REG_AW-1:0] ex_rs,
   input  logic [REG_AW-1:0]         ex_rd,
   input  logic                      ex_regwrite,
   input  logic                      ex_memread,
   input  logic [REG_AW-1:0]         mem_rd,
   input  logic                      mem_regwrite,
   input  logic                      mem_memread,
   input  logic                      mem_ready,
   input  logic [REG_AW-1:0]         wb_rd,
   input  logic                      wb_regwrite,
   input  logic                      cnt_clr,
   output logic [2*NUM_SRC-1:0]      fwd_sel,
   output logic                      stall_if,
   output logic                      stall_id,
   output logic                      bubble_ex,
   output logic                      freeze,
   output logic [CNT_W-1:0]          stall_cnt,
   output logic [CNT_W-1:0]          lu_cnt
);

   typedef enum logic [1:0] {
      RUN,
      LU,
      MWAIT
   } state_t;

   localparam logic [2:0]       LU_M1 = 3'(LU_CYCLES - 1);
   localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

   state_t     state, state_n;
   state_t     ret, ret_n;
   logic [2:0] rem, rem_n;
   logic       src_hit, hz, mw;
   logic       stl, fz, lu_hit;

   // MEM wins over WB; x0 is never forwarded
   always_comb begin
      fwd_sel = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (wb_regwrite && wb_rd != '0 &&
             wb_rd == ex_rs[i*REG_AW +: REG_AW])
            fwd_sel[2*i +: 2] = 2'b10;
         if (mem_regwrite && mem_rd != '0 &&
             mem_rd == ex_rs[i*REG_AW +: REG_AW])
            fwd_sel[2*i +: 2] = 2'b01;
      end
   end

   always_comb begin
      src_hit = 1'b0;
      for (int i = 0; i < NUM_SRC; i++)
         if (id_rs_used[i] && id_rs[i*REG_AW +: REG_AW] == ex_rd)
            src_hit = 1'b1;
   end

   assign hz = id_valid & ex_memread & ex_regwrite &
               (ex_rd != '0) & src_hit;
   assign mw = mem_memread & ~mem_ready;

   always_comb begin
      state_n = state;
      ret_n   = ret;
      rem_n   = rem;
      stl     = 1'b0;
      fz      = 1'b0;
      lu_hit  = 1'b0;
      unique case (state)
         RUN: begin
            if (mw) begin
               fz      = 1'b1;
               state_n = MWAIT;
               ret_n   = RUN;
            end else if (hz) begin
               stl    = 1'b1;
               lu_hit = 1'b1;
               if (LU_CYCLES > 1) begin
                  state_n = LU;
                  rem_n   = LU_M1;
               end
            end
         end
         LU: begin
            if (mw) begin
               fz      = 1'b1;
               state_n = MWAIT;
               ret_n   = LU;
            end else begin
               stl = 1'b1;
               if (rem <= 3'd1) begin
                  state_n = RUN;
                  rem_n   = '0;
               end else begin
                  rem_n = rem - 3'd1;
               end
            end
         end
         MWAIT: begin
            if (mem_ready) state_n = ret;
            else           fz      = 1'b1;
         end
         default: state_n = RUN;
      endcase
   end

   // reset forces the stall controls low without waiting for a clock
   assign stall_if  = rst & stl;
   assign stall_id  = rst & stl;
   assign bubble_ex = rst & stl;
   assign freeze    = rst & fz;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= RUN;
         ret   <= RUN;
         rem   <= '0;
      end else begin
         state <= state_n;
         ret   <= ret_n;
         rem   <= rem_n;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= '0;
         lu_cnt    <= '0;
      end else if (cnt_clr) begin
         stall_cnt <= '0;
         lu_cnt    <= '0;
      end else begin
         if ((stl | fz) && stall_cnt != '1)
            stall_cnt <= stall_cnt + ONE;
         if (lu_hit && lu_cnt != '1)
            lu_cnt <= lu_cnt + ONE;
      end
   end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb_hazard_fwd_unit: two instances (LU_CYCLES 1 and 3) driven in lockstep
// and checked against a bubble-budget reference model.
module tb_hazard_fwd_unit;

   localparam int NS = 2;
   localparam int AW = 5;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic            id_valid;
   logic [NS*AW-1:0] id_rs;
   logic [NS-1:0]   id_rs_used;
   logic [NS*AW-1:0] ex_rs;
   logic [AW-1:0]   ex_rd, mem_rd, wb_rd;
   logic            ex_regwrite, ex_memread;
   logic            mem_regwrite, mem_memread, mem_ready;
   logic            wb_regwrite, cnt_clr;

   logic [3:0]  fs_a, fs_b;
   logic        sif_a, sid_a, bub_a, frz_a;
   logic        sif_b, sid_b, bub_b, frz_b;
   logic [31:0] sc_a, lc_a;
   logic [3:0]  sc_b, lc_b;

   hazard_fwd_unit #(.NUM_SRC(NS), .REG_AW(AW), .LU_CYCLES(1), .CNT_W(32)) u_a (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs),
      .id_rs_used(id_rs_used), .ex_rs(ex_rs), .ex_rd(ex_rd),
      .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .mem_rd(mem_rd),
      .mem_regwrite(mem_regwrite), .mem_memread(mem_memread),
      .mem_ready(mem_ready), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
      .cnt_clr(cnt_clr), .fwd_sel(fs_a), .stall_if(sif_a), .stall_id(sid_a),
      .bubble_ex(bub_a), .freeze(frz_a), .stall_cnt(sc_a), .lu_cnt(lc_a)
   );

   hazard_fwd_unit #(.NUM_SRC(NS), .REG_AW(AW), .LU_CYCLES(3), .CNT_W(4)) u_b (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs),
      .id_rs_used(id_rs_used), .ex_rs(ex_rs), .ex_rd(ex_rd),
      .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .mem_rd(mem_rd),
      .mem_regwrite(mem_regwrite), .mem_memread(mem_memread),
      .mem_ready(mem_ready), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
      .cnt_clr(cnt_clr), .fwd_sel(fs_b), .stall_if(sif_b), .stall_id(sid_b),
      .bubble_ex(bub_b), .freeze(frz_b), .stall_cnt(sc_b), .lu_cnt(lc_b)
   );

   logic [3:0]  o_ctl [2];
   logic [3:0]  o_fs  [2];
   logic [63:0] o_sc  [2];
   logic [63:0] o_lc  [2];

   always_comb begin
      o_ctl[0] = {sif_a, sid_a, bub_a, frz_a};
      o_ctl[1] = {sif_b, sid_b, bub_b, frz_b};
      o_fs[0]  = fs_a;
      o_fs[1]  = fs_b;
      o_sc[0]  = 64'(sc_a);
      o_sc[1]  = 64'(sc_b);
      o_lc[0]  = 64'(lc_a);
      o_lc[1]  = 64'(lc_b);
   end

   // model: remaining bubbles per hazard, paused by an open memory wait
   int          lu_len [2] = '{1, 3};
   logic [63:0] cmax   [2] = '{64'hFFFF_FFFF, 64'hF};
   int          bub_left [2];
   bit          in_wait  [2];
   logic [63:0] m_sc [2];
   logic [63:0] m_lc [2];
   logic [3:0]  e_ctl [2];
   bit          n_lu  [2];

   int n_chk  = 0;
   int n_fail = 0;

   function automatic logic [3:0] exp_fs();
      logic [3:0]    r;
      logic [AW-1:0] s;
      r = '0;
      for (int i = 0; i < NS; i++) begin
         s = ex_rs[i*AW +: AW];
         if (mem_regwrite && mem_rd != 0 && mem_rd == s)
            r[2*i +: 2] = 2'b01;
         else if (wb_regwrite && wb_rd != 0 && wb_rd == s)
            r[2*i +: 2] = 2'b10;
      end
      return r;
   endfunction

   function automatic bit hz_now();
      bit any;
      any = 1'b0;
      for (int i = 0; i < NS; i++)
         if (id_rs_used[i] && id_rs[i*AW +: AW] == ex_rd) any = 1'b1;
      return id_valid && ex_memread && ex_regwrite && ex_rd != 0 && any;
   endfunction

   function automatic bit mw_now();
      return mem_memread && !mem_ready;
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         bub_left[d] = 0;
         in_wait[d]  = 1'b0;
         m_sc[d]     = '0;
         m_lc[d]     = '0;
      end
   endtask

   task automatic model_eval();
      for (int d = 0; d < 2; d++) begin
         e_ctl[d] = 4'b0000;
         n_lu[d]  = 1'b0;
         if (rst) begin
            if (in_wait[d]) begin
               e_ctl[d][0] = !mem_ready;
            end else if (mw_now()) begin
               e_ctl[d][0] = 1'b1;
            end else if (bub_left[d] > 0 || hz_now()) begin
               e_ctl[d] = 4'b1110;
               n_lu[d]  = (bub_left[d] == 0);
            end
         end
      end
   endtask

   task automatic model_commit();
      model_eval();
      if (!rst) begin
         model_reset();
         return;
      end
      for (int d = 0; d < 2; d++) begin
         if (cnt_clr) begin
            m_sc[d] = '0;
            m_lc[d] = '0;
         end else begin
            if ((e_ctl[d][2] || e_ctl[d][0]) && m_sc[d] < cmax[d])
               m_sc[d] = m_sc[d] + 1;
            if (n_lu[d] && m_lc[d] < cmax[d])
               m_lc[d] = m_lc[d] + 1;
         end
         if (in_wait[d]) begin
            if (mem_ready) in_wait[d] = 1'b0;
         end else if (mw_now()) begin
            in_wait[d] = 1'b1;
         end else if (bub_left[d] > 0) begin
            bub_left[d] = bub_left[d] - 1;
         end else if (hz_now()) begin
            bub_left[d] = lu_len[d] - 1;
         end
      end
   endtask

   task automatic tick();
      model_commit();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      id_valid     = 1'b0;
      id_rs        = '0;
      id_rs_used   = '0;
      ex_rs        = '0;
      ex_rd        = '0;
      ex_regwrite  = 1'b0;
      ex_memread   = 1'b0;
      mem_rd       = '0;
      mem_regwrite = 1'b0;
      mem_memread  = 1'b0;
      mem_ready    = 1'b1;
      wb_rd        = '0;
      wb_regwrite  = 1'b0;
      cnt_clr      = 1'b0;
   endtask

   task automatic set_load_use();
      ex_memread  = 1'b1;
      ex_regwrite = 1'b1;
      ex_rd       = 5'd7;
      id_valid    = 1'b1;
      id_rs       = {5'd7, 5'd1};
      id_rs_used  = 2'b11;
   endtask

   task automatic drain_and_clear();
      set_idle();
      repeat (3) tick();
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
   endtask

   task automatic test_reset();
      set_idle();
      set_load_use();
      mem_memread  = 1'b1;
      mem_ready    = 1'b0;
      mem_regwrite = 1'b1;
      mem_rd       = 5'd5;
      ex_rs        = {5'd5, 5'd3};
      rst          = 1'b0;
      #2;
      for (int d = 0; d < 2; d++) begin
         n_chk++;
         if (o_ctl[d] !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctl dut%0d got %b want 0000", d, o_ctl[d]);
         end
         n_chk++;
         if (o_fs[d] !== 4'b0100) begin
            n_fail++;
            $display("FAIL reset_fwd dut%0d got %b want 0100", d, o_fs[d]);
         end
      end
      tick();
      tick();
      for (int d = 0; d < 2; d++) begin
         n_chk++;
         if (o_sc[d] !== 0 || o_lc[d] !== 0) begin
            n_fail++;
            $display("FAIL reset_cnt dut%0d got %0d/%0d want 0/0",
                     d, o_sc[d], o_lc[d]);
         end
      end
      set_idle();
      rst = 1'b1;
      model_reset();
      tick();
   endtask

   task automatic test_forwarding();
      logic [3:0] want [3] = '{4'b0101, 4'b1001, 4'b0000};
      for (int k = 0; k < 3; k++) begin
         set_idle();
         mem_regwrite = 1'b1;
         wb_regwrite  = 1'b1;
         mem_rd       = 5'd5;
         wb_rd        = 5'd5;
         ex_rs        = {5'd5, 5'd5};
         if (k == 1) begin
            wb_rd = 5'd6;
            ex_rs = {5'd6, 5'd5};
         end
         if (k == 2) begin
            mem_rd = 5'd0;
            wb_rd  = 5'd0;
            ex_rs  = '0;
         end
         #1;
         for (int d = 0; d < 2; d++) begin
            n_chk++;
            if (o_fs[d] !== want[k]) begin
               n_fail++;
               $display("FAIL fwd_dir%0d dut%0d got %b want %b",
                        k, d, o_fs[d], want[k]);
            end
         end
      end
      for (int k = 0; k < 40; k++) begin
         mem_regwrite = 1'($urandom);
         wb_regwrite  = 1'($urandom);
         mem_rd       = 5'($urandom_range(0, 3));
         wb_rd        = 5'($urandom_range(0, 3));
         ex_rs        = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
         #1;
         for (int d = 0; d < 2; d++) begin
            n_chk++;
            if (o_fs[d] !== exp_fs()) begin
               n_fail++;
               $display("FAIL fwd_rand%0d dut%0d got %b want %b",
                        k, d, o_fs[d], exp_fs());
            end
         end
      end
      set_idle();
      tick();
   endtask

   task automatic test_load_use();
      drain_and_clear();
      for (int c = 0; c < 5; c++) begin
         set_idle();
         if (c == 0) set_load_use();
         if (c == 1) begin
            id_valid     = 1'b1;
            id_rs        = {5'd7, 5'd1};
            id_rs_used   = 2'b11;
            mem_memread  = 1'b1;
            mem_regwrite = 1'b1;
            mem_rd       = 5'd7;
         end
         if (c == 2) begin
            wb_regwrite = 1'b1;
            wb_rd       = 5'd7;
            ex_rs       = {5'd7, 5'd1};
         end
         #1;
         model_eval();
         for (int d = 0; d < 2; d++) begin
            n_chk++;
            if (o_ctl[d] !== e_ctl[d]) begin
               n_fail++;
               $display("FAIL lu_ctl c%0d dut%0d got %b want %b",
                        c, d, o_ctl[d], e_ctl[d]);
            end
         end
         if (c == 2) begin
            n_chk++;
            if (fs_a[3:2] !== 2'b10) begin
               n_fail++;
               $display("FAIL lu_fwd got %b want 10", fs_a[3:2]);
            end
         end
         tick();
      end
      n_chk++;
      if (lc_a !== 32'd1 || sc_a !== 32'd1) begin
         n_fail++;
         $display("FAIL lu_cnt_a got lu=%0d st=%0d want 1/1", lc_a, sc_a);
      end
      n_chk++;
      if (lc_b !== 4'd1 || sc_b !== 4'd3) begin
         n_fail++;
         $display("FAIL lu_cnt_b got lu=%0d st=%0d want 1/3", lc_b, sc_b);
      end
   endtask

   task automatic test_mem_wait();
      int nb [2];
      drain_and_clear();
      for (int k = 0; k < 6; k++) begin
         set_idle();
         mem_memread = (k < 5);
         mem_ready   = (k >= 4);
         #1;
         for (int d = 0; d < 2; d++) begin
            n_chk++;
            if (o_ctl[d] !== ((k < 4) ? 4'b0001 : 4'b0000)) begin
               n_fail++;
               $display("FAIL mw_frz k%0d dut%0d got %b want %b",
                        k, d, o_ctl[d], (k < 4) ? 4'b0001 : 4'b0000);
            end
         end
         tick();
      end
      nb = '{0, 0};
      for (int c = 0; c < 8; c++) begin
         set_idle();
         if (c == 0) set_load_use();
         mem_memread = (c >= 1 && c <= 4);
         mem_ready   = !(c >= 1 && c <= 3);
         #1;
         model_eval();
         for (int d = 0; d < 2; d++) begin
            nb[d] += int'(o_ctl[d][1]);
            n_chk++;
            if (o_ctl[d] !== e_ctl[d]) begin
               n_fail++;
               $display("FAIL mw_lu c%0d dut%0d got %b want %b",
                        c, d, o_ctl[d], e_ctl[d]);
            end
         end
         tick();
      end
      n_chk++;
      if (nb[0] != 1 || nb[1] != 3) begin
         n_fail++;
         $display("FAIL mw_bubbles got %0d/%0d want 1/3", nb[0], nb[1]);
      end
   endtask

   task automatic test_saturation();
      drain_and_clear();
      set_idle();
      mem_memread = 1'b1;
      mem_ready   = 1'b0;
      repeat (14) tick();
      n_chk++;
      if (sc_b !== 4'd14) begin
         n_fail++;
         $display("FAIL sat_pre got %0d want 14", sc_b);
      end
      repeat (3) tick();
      n_chk++;
      if (sc_b !== 4'hF || sc_a !== 32'd17) begin
         n_fail++;
         $display("FAIL sat got %0d/%0d want 15/17", sc_b, sc_a);
      end
      cnt_clr = 1'b1;
      #1;
      n_chk++;
      if (frz_a !== 1'b1 || frz_b !== 1'b1) begin
         n_fail++;
         $display("FAIL sat_frz got %b%b want 11", frz_a, frz_b);
      end
      tick();
      for (int d = 0; d < 2; d++) begin
         n_chk++;
         if (o_sc[d] !== 0) begin
            n_fail++;
            $display("FAIL clr_prio dut%0d got %0d want 0", d, o_sc[d]);
         end
      end
      set_idle();
      tick();
   endtask

   task automatic test_reset_mid_lu();
      drain_and_clear();
      set_load_use();
      tick();
      set_idle();
      #1;
      n_chk++;
      if (o_ctl[1] !== 4'b1110) begin
         n_fail++;
         $display("FAIL rst_pre got %b want 1110", o_ctl[1]);
      end
      rst = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         n_chk++;
         if (o_ctl[d] !== 4'b0000) begin
            n_fail++;
            $display("FAIL rst_async dut%0d got %b want 0000", d, o_ctl[d]);
         end
      end
      tick();
      rst = 1'b1;
      #1;
      for (int d = 0; d < 2; d++) begin
         n_chk++;
         if (o_ctl[d] !== 4'b0000 || o_sc[d] !== 0 || o_lc[d] !== 0) begin
            n_fail++;
            $display("FAIL rst_post dut%0d got %b %0d %0d want 0000 0 0",
                     d, o_ctl[d], o_sc[d], o_lc[d]);
         end
      end
      tick();
      for (int c = 0; c < 4; c++) begin
         set_idle();
         if (c == 0) set_load_use();
         #1;
         model_eval();
         n_chk++;
         if (o_ctl[1] !== e_ctl[1] || o_ctl[1] !== ((c < 3) ? 4'b1110 : 4'b0000)) begin
            n_fail++;
            $display("FAIL rst_run c%0d got %b want %b", c, o_ctl[1], e_ctl[1]);
         end
         tick();
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 500; k++) begin
         id_valid     = 1'($urandom);
         id_rs        = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
         id_rs_used   = 2'($urandom);
         ex_rs        = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
         ex_rd        = 5'($urandom_range(0, 3));
         ex_regwrite  = 1'($urandom);
         ex_memread   = ($urandom_range(0, 2) == 0);
         mem_rd       = 5'($urandom_range(0, 3));
         mem_regwrite = 1'($urandom);
         mem_memread  = ($urandom_range(0, 3) == 0);
         mem_ready    = ($urandom_range(0, 2) != 0);
         wb_rd        = 5'($urandom_range(0, 3));
         wb_regwrite  = 1'($urandom);
         cnt_clr      = ($urandom_range(0, 49) == 0);
         #1;
         model_eval();
         for (int d = 0; d < 2; d++) begin
            n_chk++;
            if (o_ctl[d] !== e_ctl[d] || o_fs[d] !== exp_fs()) begin
               n_fail++;
               $display("FAIL rnd_out k%0d dut%0d got %b/%b want %b/%b",
                        k, d, o_ctl[d], o_fs[d], e_ctl[d], exp_fs());
            end
            n_chk++;
            if (o_sc[d] !== m_sc[d] || o_lc[d] !== m_lc[d]) begin
               n_fail++;
               $display("FAIL rnd_cnt k%0d dut%0d got %0d/%0d want %0d/%0d",
                        k, d, o_sc[d], o_lc[d], m_sc[d], m_lc[d]);
            end
         end
         tick();
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_forwarding();
      test_load_use();
      test_mem_wait();
      test_saturation();
      test_reset_mid_lu();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
